// File: rtl/fir_rd_pkg.sv
// Shared types and constants for the FIR result reader (FSM states, byte width,
// default sizing) plus the byte parity helper.
package fir_rd_pkg;

  localparam int BYTE_W     = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } fir_rd_state_e;

  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/fir_rd_fifo.sv
// Sample FIFO for the FIR result reader. A push into a full FIFO is accepted only
// when a pop happens on the same edge; flags are registered.
module fir_rd_fifo
  import fir_rd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        head,
  output logic [DATA_W-1:0]        next_head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt_s;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              wr_en_s, rd_en_s;

  always_comb begin
    wr_en_s  = push & (~full_q | pop);
    rd_en_s  = pop & ~empty_q;
    rd_nxt_s = rd_ptr_q + PTR_ONE;
    mem_d    = mem_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_nxt_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (wr_en_s && !rd_en_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_en_s && rd_en_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
    full_d  = (count_d == CNT_DEPTH);
    empty_d = (count_d == {CNT_W{1'b0}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // With one entry left, the word following the head can only be this cycle's push.
  assign next_head = (count_q > CNT_ONE) ? mem_q[rd_nxt_s] : wdata;
  assign head      = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;

endmodule

// File: rtl/fir_result_reader.sv
// Drains 16-bit FIR results as high/low byte pairs over a valid/ack handshake.
// Optional byte parity register is built when FIR_RD_PARITY_EN is defined.
module fir_result_reader
  import fir_rd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] y_dat,
  input  logic              y_lz,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ack,
  output logic              byte_hi,
  output logic              byte_par,
  input  logic              ovf_clr,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fir_rd_state_e     state_q, state_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d, hi_q, hi_d, ovf_q, ovf_d;
  logic              pop_s, ovf_set_s, more_s;
  logic [DATA_W-1:0] head_s, next_head_s, sel_word_s;
  logic [CNT_W-1:0]  count_s;

  fir_rd_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (y_lz),
    .pop       (pop_s),
    .wdata     (y_dat),
    .head      (head_s),
    .next_head (next_head_s),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count_s)
  );

  always_comb begin
    pop_s      = valid_q & byte_ack & (state_q == SEND_LO);
    ovf_set_s  = y_lz & fifo_full & ~pop_s;
    more_s     = (count_s > CNT_ONE) | y_lz;
    sel_word_s = (state_q == SEND_LO) ? next_head_s : head_s;
    state_d    = state_q;
    byte_d     = byte_q;
    valid_d    = valid_q;
    hi_d       = hi_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          byte_d  = sel_word_s[DATA_W-1 -: BYTE_W];
          valid_d = 1'b1;
          hi_d    = 1'b1;
          state_d = SEND_HI;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_HI: begin
        if (byte_ack) begin
          byte_d  = sel_word_s[BYTE_W-1:0];
          hi_d    = 1'b0;
          state_d = SEND_LO;
        end else begin
          state_d = SEND_HI;
        end
      end
      SEND_LO: begin
        if (byte_ack && more_s) begin
          byte_d  = sel_word_s[DATA_W-1 -: BYTE_W];
          hi_d    = 1'b1;
          state_d = SEND_HI;
        end else if (byte_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = SEND_LO;
        end
      end
      default: begin
        valid_d = 1'b0;
        hi_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
    // A drop and a clear on the same edge leave the flag set.
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= {BYTE_W{1'b0}};
      valid_q <= 1'b0;
      hi_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FIR_RD_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = even_parity(byte_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign byte_par = par_q;
`else
  assign byte_par = 1'b0;
`endif

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign byte_hi    = hi_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_fir_result_reader.sv
// Directed self-checking bench for fir_result_reader (DEPTH=4, DATA_W=16).
module tb_fir_result_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] y_dat = 16'h0000;
  logic        y_lz = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ack = 1'b0;
  logic        byte_hi;
  logic        byte_par;
  logic        ovf_clr = 1'b0;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  fir_result_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y_dat      (y_dat),
    .y_lz       (y_lz),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ack   (byte_ack),
    .byte_hi    (byte_hi),
    .byte_par   (byte_par),
    .ovf_clr    (ovf_clr),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic exp_par(input logic [7:0] b);
`ifdef FIR_RD_PARITY_EN
    return ^b;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; y_lz = 1'b0; byte_ack = 1'b0; ovf_clr = 1'b0; y_dat = 16'h0000;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_seq(input logic [15:0] first, input logic [15:0] step, input int n);
    for (int i = 0; i < n; i++) begin
      y_dat = first + step * i[15:0];
      y_lz  = 1'b1;
      tick();
    end
    y_lz = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({byte_out, byte_valid, byte_hi, byte_par, fifo_full, fifo_empty, overflow} !== {8'h00, 6'b000010}) begin
      n_err++;
      $display("FAIL reset_values: got out=%h v=%b hi=%b par=%b full=%b empty=%b ovf=%b, expected 00 0 0 0 0 1 0",
               byte_out, byte_valid, byte_hi, byte_par, fifo_full, fifo_empty, overflow);
    end
  endtask

  task automatic test_single();
    byte_ack = 1'b1;
    y_dat = 16'hA55A; y_lz = 1'b1;
    tick();
    y_lz = 1'b0;
    n_cmp++;
    if (byte_valid !== 1'b0 || fifo_empty !== 1'b0) begin
      n_err++;
      $display("FAIL single_n1: got valid=%b empty=%b, expected valid=0 empty=0", byte_valid, fifo_empty);
    end
    tick();
    n_cmp++;
    if (byte_valid !== 1'b1 || byte_out !== 8'hA5 || byte_hi !== 1'b1 || byte_par !== exp_par(8'hA5)) begin
      n_err++;
      $display("FAIL single_hi: got v=%b out=%h hi=%b par=%b, expected v=1 out=a5 hi=1 par=%b",
               byte_valid, byte_out, byte_hi, byte_par, exp_par(8'hA5));
    end
    tick();
    n_cmp++;
    if (byte_valid !== 1'b1 || byte_out !== 8'h5A || byte_hi !== 1'b0 || byte_par !== exp_par(8'h5A)) begin
      n_err++;
      $display("FAIL single_lo: got v=%b out=%h hi=%b par=%b, expected v=1 out=5a hi=0 par=%b",
               byte_valid, byte_out, byte_hi, byte_par, exp_par(8'h5A));
    end
    tick();
    n_cmp++;
    if (byte_valid !== 1'b0 || fifo_empty !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: got valid=%b empty=%b, expected valid=0 empty=1", byte_valid, fifo_empty);
    end
    byte_ack = 1'b0;
  endtask

  task automatic test_stall();
    byte_ack = 1'b0;
    y_dat = 16'hA55A; y_lz = 1'b1;
    tick();
    y_lz = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (byte_valid !== 1'b1 || byte_out !== 8'hA5 || byte_hi !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b out=%h hi=%b, expected v=1 out=a5 hi=1",
                 i, byte_valid, byte_out, byte_hi);
      end
      tick();
    end
    byte_ack = 1'b1;
    tick();
    n_cmp++;
    if (byte_valid !== 1'b1 || byte_out !== 8'h5A || byte_hi !== 1'b0) begin
      n_err++;
      $display("FAIL stall_lo: got v=%b out=%h hi=%b, expected v=1 out=5a hi=0", byte_valid, byte_out, byte_hi);
    end
    tick();
    n_cmp++;
    if (byte_valid !== 1'b0 || fifo_empty !== 1'b1) begin
      n_err++;
      $display("FAIL stall_done: got valid=%b empty=%b, expected valid=0 empty=1", byte_valid, fifo_empty);
    end
    byte_ack = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b [8];
    logic       eh;
    exp_b = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04};
    byte_ack = 1'b0;
    push_seq(16'h0101, 16'h0101, 5);
    n_cmp++;
    if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flags: got full=%b ovf=%b, expected full=1 ovf=1", fifo_full, overflow);
    end
    byte_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      eh = (i % 2 == 0);
      n_cmp++;
      if (byte_valid !== 1'b1 || byte_out !== exp_b[i] || byte_hi !== eh || byte_par !== exp_par(exp_b[i])) begin
        n_err++;
        $display("FAIL ovf_drain[%0d]: got v=%b out=%h hi=%b par=%b, expected v=1 out=%h hi=%b par=%b",
                 i, byte_valid, byte_out, byte_hi, byte_par, exp_b[i], eh, exp_par(exp_b[i]));
      end
      tick();
    end
    byte_ack = 1'b0;
    n_cmp++;
    if (byte_valid !== 1'b0 || fifo_empty !== 1'b1 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_after_drain: got v=%b empty=%b ovf=%b, expected v=0 empty=1 ovf=1",
               byte_valid, fifo_empty, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got ovf=%b, expected 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b [8];
    logic       eh;
    exp_b = '{8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h55, 8'h55};
    byte_ack = 1'b0;
    push_seq(16'h1111, 16'h1111, 4);
    byte_ack = 1'b1;
    tick();
    n_cmp++;
    if (byte_out !== 8'h11 || byte_hi !== 1'b0 || fifo_full !== 1'b1) begin
      n_err++;
      $display("FAIL fpp_lo: got out=%h hi=%b full=%b, expected out=11 hi=0 full=1", byte_out, byte_hi, fifo_full);
    end
    y_dat = 16'h5555; y_lz = 1'b1;
    tick();
    y_lz = 1'b0;
    byte_ack = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0 || fifo_full !== 1'b1 || byte_out !== 8'h22 || byte_hi !== 1'b1) begin
      n_err++;
      $display("FAIL fpp_accept: got ovf=%b full=%b out=%h hi=%b, expected ovf=0 full=1 out=22 hi=1",
               overflow, fifo_full, byte_out, byte_hi);
    end
    byte_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      eh = (i % 2 == 0);
      n_cmp++;
      if (byte_valid !== 1'b1 || byte_out !== exp_b[i] || byte_hi !== eh) begin
        n_err++;
        $display("FAIL fpp_drain[%0d]: got v=%b out=%h hi=%b, expected v=1 out=%h hi=%b",
                 i, byte_valid, byte_out, byte_hi, exp_b[i], eh);
      end
      tick();
    end
    byte_ack = 1'b0;
    n_cmp++;
    if (byte_valid !== 1'b0 || fifo_empty !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL fpp_done: got v=%b empty=%b ovf=%b, expected v=0 empty=1 ovf=0", byte_valid, fifo_empty, overflow);
    end
  endtask

  task automatic test_ovf_set_clr();
    byte_ack = 1'b0;
    push_seq(16'h0A0A, 16'h0101, 4);
    y_dat = 16'hDEAD; y_lz = 1'b1; ovf_clr = 1'b1;
    tick();
    y_lz = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set_wins: got ovf=%b, expected 1", overflow);
    end
    tick();
    ovf_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr_alone: got ovf=%b, expected 0", overflow);
    end
  endtask

  task automatic test_reset_mid_transfer();
    apply_reset();
    push_seq(16'h1234, 16'h4444, 3);
    tick();
    byte_ack = 1'b1;
    tick();
    byte_ack = 1'b0;
    n_cmp++;
    if (byte_valid !== 1'b1 || byte_out !== 8'h34 || byte_hi !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pre: got v=%b out=%h hi=%b, expected v=1 out=34 hi=0", byte_valid, byte_out, byte_hi);
    end
    #2;
    rst_n = 1'b0;
    byte_ack = 1'b1;
    #1;
    n_cmp++;
    if ({byte_out, byte_valid, byte_hi, byte_par, fifo_full, fifo_empty, overflow} !== {8'h00, 6'b000010}) begin
      n_err++;
      $display("FAIL rst_async: got out=%h v=%b hi=%b par=%b full=%b empty=%b ovf=%b, expected 00 0 0 0 0 1 0",
               byte_out, byte_valid, byte_hi, byte_par, fifo_full, fifo_empty, overflow);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (byte_valid !== 1'b0 || fifo_empty !== 1'b1) begin
        n_err++;
        $display("FAIL rst_quiet[%0d]: got v=%b empty=%b, expected v=0 empty=1", i, byte_valid, fifo_empty);
      end
    end
    byte_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_full_push_pop();
    test_ovf_set_clr();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_result_reader.md
# fir_result_reader

Consumer end of the FIR filter's result port. Captures each 16-bit output sample when the filter's `y_triosy_lz` strobe pulses, buffers it in a small FIFO, and presents it as two 8-bit bytes (high then low) over a valid/ack byte handshake. This lets a narrow 8-bit pin bus drain full-precision results. It sits between the `fir` core's `y_rsc_dat`/`y_triosy_lz` outputs and the chip's dedicated output pins.

## Interface
- `DATA_W`, 16, sample width; must equal 2×8.
- `DEPTH`, 4, FIFO depth in samples; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `y_dat`  in  DATA_W  FIR result sample.
- `y_lz`  in  1  one-cycle strobe: `y_dat` valid this cycle.
- `byte_out`  out  8  current output byte.
- `byte_valid`  out  1  `byte_out` holds an unconsumed byte.
- `byte_ack`  in  1  consumer takes the byte on a cycle where `byte_valid` & `byte_ack`.
- `byte_hi`  out  1  1 = `byte_out` is the high byte [15:8], 0 = low byte [7:0].
- `byte_par`  out  1  even parity of `byte_out` (see Configuration).
- `ovf_clr`  in  1  synchronous clear of `overflow`.
- `fifo_full`, `fifo_empty`  out  1 each  FIFO status.
- `overflow`  out  1  sticky: a sample was dropped.

## Operation
- Reset values: `byte_out`=0, `byte_valid`=0, `byte_hi`=0, `byte_par`=0, `fifo_full`=0, `fifo_empty`=1, `overflow`=0. FSM is in IDLE, and pointers and count are 0.
- Push: on `y_lz`=1, write `y_dat` at the write pointer, unless the FIFO is full and no pop happens this cycle.
- If the FIFO is full and no pop occurs, drop the sample and set `overflow`.
- If the FIFO is full and a pop occurs in the same cycle, accept the push. Count is unchanged.
- `overflow` stays set until `ovf_clr`=1. If a set and a clear happen in the same cycle, set wins.
- Pointers are log2(DEPTH) bits and wrap naturally. A count of log2(DEPTH)+1 bits gives full (count==DEPTH) and empty (count==0).
- FSM states:
  - IDLE: if the FIFO is not empty, load the head sample's [15:8] into `byte_out`, assert `byte_valid` and `byte_hi`, and go to SEND_HI.
  - SEND_HI: on ack, load [7:0] into `byte_out`, set `byte_hi`=0, and go to SEND_LO.
  - SEND_LO: on ack, pop the head sample. If the FIFO is then not empty (count after pop >0, including a push in the same cycle), load the next high byte and go to SEND_HI. Otherwise deassert `byte_valid` and go to IDLE.
- `byte_out`, `byte_hi` and `byte_par` must stay stable while `byte_valid`=1 and no ack has occurred. `byte_ack` is ignored while `byte_valid`=0.
- The sample is popped only after its low byte is acked. The head stays in the FIFO during SEND_HI and SEND_LO, so a sample is never partly lost.
- Asserting `rst_n`=0 mid-transfer aborts the transfer immediately: all state returns to reset values and buffered samples are discarded.

## Timing
- `y_lz` in cycle n while IDLE and empty: the sample is written at edge n. `byte_valid`=1 with the high byte from cycle n+2.
- The high-byte ack at cycle m gives the low byte at m+1. The low-byte ack at m gives the next high byte at m+1, or `byte_valid`=0 at m+1.
- Peak throughput is 1 byte/cycle with `byte_ack` held high, i.e. one sample per 2 cycles.
- `fifo_full`, `fifo_empty` and `overflow` are registered and reflect state after the previous edge.
- All outputs are registered. There is no combinational path from `byte_ack` or `y_lz` to any output.

## Configuration
- `FIR_RD_PARITY_EN` defined: `byte_par` is a register equal to the XOR of the loaded `byte_out` bits, updated on the same edge as `byte_out`.
- Undefined: `byte_par` is tied to 0 and no parity logic is built. Everything else is identical.

## Structure
- Package `fir_rd_pkg`: state enum (IDLE, SEND_HI, SEND_LO), `BYTE_W`=8, default `DEPTH` and `DATA_W` constants.
- Sub-module `fir_rd_fifo`: synchronous FIFO with push, pop, head data, full, empty and count. It handles simultaneous push and pop when full. The top level holds the FSM, byte mux, overflow flag and parity.

## Test plan
- Single sample 0xA55A, `byte_ack` held 1: bytes 0xA5 (hi=1) then 0x5A (hi=0) appear 2 and 3 cycles after `y_lz`; `fifo_empty`=1 afterwards. With the macro, `byte_par` is 0 then 0.
- `byte_ack` held 0 for 10 cycles after the high byte: `byte_out`=0xA5 stays stable, and the low byte follows the first ack.
- Five samples 0x0101..0x0505 pushed back-to-back with no acks (`DEPTH`=4): `fifo_full`=1, `overflow`=1, and draining yields only 0x0101..0x0404. `ovf_clr` then clears the flag.
- Full FIFO with `y_lz` in the same cycle as the low-byte ack: the new sample is accepted, `overflow` stays 0, and `fifo_full` stays 1.
- Overflow set and `ovf_clr` in the same cycle: `overflow`=1.
- `rst_n` pulsed low during SEND_LO with 3 samples buffered: all outputs return to reset values immediately and no bytes are emitted after reset.
